// File: rtl/pong_game_engine_if.sv
// Control inputs and registered object state exchanged between the pong engine
// and its neighbours (VGA timing, buttons, renderer).
interface pong_game_engine_if;
  logic        GameOn;
  logic        GameStartdb;
  logic        Bar_up;
  logic        Bar_down;
  logic [16:0] HCount;
  logic [16:0] VCount;
  logic [10:0] BallX;
  logic [10:0] BallY;
  logic [10:0] PaddleY;
  logic [7:0]  Score;
  logic [1:0]  Lives;
  logic [1:0]  GameState;
  logic        FrameTick;

  modport slave (
    input  GameOn, GameStartdb, Bar_up, Bar_down, HCount, VCount,
    output BallX, BallY, PaddleY, Score, Lives, GameState, FrameTick
  );

  modport master (
    output GameOn, GameStartdb, Bar_up, Bar_down, HCount, VCount,
    input  BallX, BallY, PaddleY, Score, Lives, GameState, FrameTick
  );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game state and physics: commits ball, paddle, score and lives once per
// frame at the start of vertical blanking; serve/play/over sequencing in an FSM.
module pong_game_engine #(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int BALL_SIZE    = 16,
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_X     = 32,
  parameter int PADDLE_W     = 12,
  parameter int PADDLE_H     = 96,
  parameter int PADDLE_STEP  = 8,
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               CLK_65MHz,
  input  logic               Clear,
  pong_game_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SERVE = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] C_X0   = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] C_Y0   = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] C_P0   = 11'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [10:0] C_XMAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] C_YMAX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] C_PMAX = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [10:0] C_FACE = 11'(PADDLE_X + PADDLE_W);
  localparam logic [11:0] C_H    = 12'(H_ACTIVE);
  localparam logic [11:0] C_V    = 12'(V_ACTIVE);
  localparam logic [11:0] C_SIZE = 12'(BALL_SIZE);
  localparam logic [11:0] C_SPD  = 12'(BALL_SPEED);
  localparam logic [11:0] C_PH   = 12'(PADDLE_H);
  localparam logic [11:0] C_STEP = 12'(PADDLE_STEP);
  localparam logic [11:0] C_F12  = 12'(PADDLE_X + PADDLE_W);
  localparam logic [1:0]  C_LIV  = 2'(LIVES_INIT);
  localparam logic [CW-1:0] C_SLAST = CW'(SERVE_FRAMES - 1);

  state_t        r_state, w_state_nxt;
  logic [10:0]   r_ball_x, r_ball_y, r_paddle_y;
  logic [10:0]   w_x_nxt, w_y_nxt, w_p_nxt;
  logic          r_dx, r_dy, w_dx_nxt, w_dy_nxt;   // dx: 1=right, dy: 1=down
  logic [7:0]    r_score, w_score_nxt;
  logic [1:0]    r_lives, w_lives_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_start_prev, r_frame_tick;

  logic          w_tick, w_start_edge;
  logic [11:0]   w_bx, w_by, w_py;
  logic [10:0]   w_vy, w_pad;
  logic          w_vdy, w_wall, w_hit, w_miss;

  assign w_tick       = (bus.HCount == 17'd0) && (bus.VCount == 17'(V_ACTIVE));
  assign w_start_edge = bus.GameStartdb & ~r_start_prev;

  // 12-bit views so edge tests never wrap
  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};
  assign w_py = {1'b0, r_paddle_y};

  assign w_wall = r_dx && (w_bx + C_SIZE + C_SPD > C_H);
  assign w_hit  = !r_dx && (w_bx >= C_F12) && (w_bx - C_SPD < C_F12)
                  && (w_by + C_SIZE > w_py) && (w_by < w_py + C_PH);
  assign w_miss = !r_dx && (w_bx < C_SPD);

  always_comb begin
    w_vy  = r_ball_y;
    w_vdy = r_dy;
    if (!r_dy && (w_by < C_SPD)) begin
      w_vy  = 11'd0;
      w_vdy = 1'b1;
    end else if (r_dy && (w_by + C_SIZE + C_SPD > C_V)) begin
      w_vy  = C_YMAX;
      w_vdy = 1'b0;
    end else if (r_dy) begin
      w_vy = 11'(w_by + C_SPD);
    end else begin
      w_vy = 11'(w_by - C_SPD);
    end
  end

  always_comb begin
    w_pad = r_paddle_y;
    if (bus.Bar_up && !bus.Bar_down)
      w_pad = (w_py < C_STEP) ? 11'd0 : 11'(w_py - C_STEP);
    else if (bus.Bar_down && !bus.Bar_up)
      w_pad = (w_py + C_STEP > {1'b0, C_PMAX}) ? C_PMAX : 11'(w_py + C_STEP);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_ball_x;
    w_y_nxt     = r_ball_y;
    w_p_nxt     = r_paddle_y;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_score_nxt = r_score;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    if (!bus.GameOn) begin
      w_state_nxt = S_IDLE;
      w_x_nxt     = C_X0;
      w_y_nxt     = C_Y0;
      w_p_nxt     = C_P0;
      w_dx_nxt    = 1'b1;
      w_dy_nxt    = 1'b1;
      w_lives_nxt = 2'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_edge) begin
            w_state_nxt = S_SERVE;
            w_score_nxt = 8'd0;
            w_lives_nxt = C_LIV;
            w_cnt_nxt   = '0;
            w_x_nxt     = C_X0;
            w_y_nxt     = C_Y0;
            w_dx_nxt    = 1'b1;
            w_dy_nxt    = 1'b1;
          end
        end
        S_SERVE: begin
          if (w_tick) begin
            w_p_nxt = w_pad;
            if (r_cnt == C_SLAST) w_state_nxt = S_PLAY;
            else                  w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
        S_PLAY: begin
          if (w_tick) begin
            w_p_nxt  = w_pad;
            w_y_nxt  = w_vy;
            w_dy_nxt = w_vdy;
            if (w_wall) begin
              w_x_nxt  = C_XMAX;
              w_dx_nxt = 1'b0;
            end else if (w_hit) begin
              w_x_nxt     = C_FACE;
              w_dx_nxt    = 1'b1;
              w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            end else if (w_miss) begin
              w_lives_nxt = r_lives - 2'd1;
              if (r_lives == 2'd1) begin
                // last life: freeze against the left edge
                w_state_nxt = S_OVER;
                w_x_nxt     = 11'd0;
              end else begin
                w_state_nxt = S_SERVE;
                w_cnt_nxt   = '0;
                w_x_nxt     = C_X0;
                w_y_nxt     = C_Y0;
                w_dx_nxt    = 1'b1;
                w_dy_nxt    = 1'b1;
              end
            end else if (r_dx) begin
              w_x_nxt = 11'(w_bx + C_SPD);
            end else begin
              w_x_nxt = 11'(w_bx - C_SPD);
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_65MHz) begin
    if (Clear) begin
      r_state      <= S_IDLE;
      r_ball_x     <= C_X0;
      r_ball_y     <= C_Y0;
      r_paddle_y   <= C_P0;
      r_dx         <= 1'b1;
      r_dy         <= 1'b1;
      r_score      <= 8'd0;
      r_lives      <= 2'd0;
      r_cnt        <= '0;
      r_start_prev <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ball_x     <= w_x_nxt;
      r_ball_y     <= w_y_nxt;
      r_paddle_y   <= w_p_nxt;
      r_dx         <= w_dx_nxt;
      r_dy         <= w_dy_nxt;
      r_score      <= w_score_nxt;
      r_lives      <= w_lives_nxt;
      r_cnt        <= w_cnt_nxt;
      r_start_prev <= bus.GameStartdb;
      r_frame_tick <= w_tick;
    end
  end

  assign bus.BallX     = r_ball_x;
  assign bus.BallY     = r_ball_y;
  assign bus.PaddleY   = r_paddle_y;
  assign bus.Score     = r_score;
  assign bus.Lives     = r_lives;
  assign bus.GameState = r_state;
  assign bus.FrameTick = r_frame_tick;

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: frame ticks are forced through
// HCount/VCount and object state is compared with hand-traced trajectories.
module tb_pong_game_engine;
  logic clk = 1'b0;
  logic clear;
  int   n_tests = 0;
  int   n_fail  = 0;

  pong_game_engine_if bus ();

  pong_game_engine dut (
    .CLK_65MHz (clk),
    .Clear     (clear),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.HCount = 17'd0;
      bus.VCount = 17'd768;
      cyc();
      bus.HCount = 17'd5;
      bus.VCount = 17'd5;
      cyc();
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear           = 1'b1;
    bus.GameOn      = 1'b0;
    bus.GameStartdb = 1'b0;
    bus.Bar_up      = 1'b0;
    bus.Bar_down    = 1'b0;
    bus.HCount      = 17'd5;
    bus.VCount      = 17'd5;
    cyc();
    clear = 1'b0;
    chk("rst_x", bus.BallX, 504);
    chk("rst_y", bus.BallY, 376);
    chk("rst_pad", bus.PaddleY, 336);
    chk("rst_score", bus.Score, 0);
    chk("rst_lives", bus.Lives, 0);
    chk("rst_state", bus.GameState, 0);
    chk("rst_ftick", bus.FrameTick, 0);
    ticks(1);
    chk("idle_tick_state", bus.GameState, 0);
    chk("idle_tick_x", bus.BallX, 504);

    // game 1: start, paddle exercise during serve
    bus.GameOn = 1'b1; bus.GameStartdb = 1'b1;
    cyc();
    chk("g1_state", bus.GameState, 1);
    chk("g1_lives", bus.Lives, 3);
    chk("g1_score", bus.Score, 0);
    bus.Bar_up = 1'b1; bus.Bar_down = 1'b1;
    ticks(10);
    chk("pad_both", bus.PaddleY, 336);
    bus.Bar_up = 1'b0;
    ticks(2);
    chk("pad_down", bus.PaddleY, 352);
    bus.Bar_down = 1'b0; bus.Bar_up = 1'b1;
    ticks(2);
    chk("pad_up", bus.PaddleY, 336);
    bus.Bar_up = 1'b0;
    ticks(45);
    chk("serve59_state", bus.GameState, 1);
    chk("serve59_x", bus.BallX, 504);
    bus.HCount = 17'd0; bus.VCount = 17'd768;
    cyc();
    chk("play_state", bus.GameState, 2);
    chk("play_x0", bus.BallX, 504);
    chk("play_y0", bus.BallY, 376);
    chk("ftick_hi", bus.FrameTick, 1);
    bus.HCount = 17'd5; bus.VCount = 17'd5;
    cyc();
    chk("ftick_lo", bus.FrameTick, 0);
    ticks(1);
    chk("t1_x", bus.BallX, 508);
    chk("t1_y", bus.BallY, 380);
    ticks(93);
    chk("t94_y", bus.BallY, 752);
    ticks(1);
    chk("t95_y_clamp", bus.BallY, 752);
    ticks(1);
    chk("t96_y_up", bus.BallY, 748);
    ticks(30);
    chk("t126_x", bus.BallX, 1008);
    ticks(1);
    chk("t127_x_clamp", bus.BallX, 1008);
    ticks(1);
    chk("t128_x_left", bus.BallX, 1004);
    ticks(155);
    chk("t283_y", bus.BallY, 0);
    ticks(1);
    chk("t284_y_clamp", bus.BallY, 0);
    ticks(1);
    chk("t285_y_down", bus.BallY, 4);
    ticks(83);
    chk("t368_x", bus.BallX, 44);
    chk("t368_y", bus.BallY, 336);
    chk("t368_score", bus.Score, 0);
    ticks(1);
    chk("hit_x", bus.BallX, 44);
    chk("hit_score", bus.Score, 1);
    ticks(1);
    chk("t370_x", bus.BallX, 48);
    chk("t370_y", bus.BallY, 344);

    // GameOn low: back to idle, score kept, start edge ignored
    bus.GameOn = 1'b0; bus.GameStartdb = 1'b0;
    cyc();
    chk("off_state", bus.GameState, 0);
    chk("off_score", bus.Score, 1);
    chk("off_lives", bus.Lives, 0);
    chk("off_x", bus.BallX, 504);
    chk("off_y", bus.BallY, 376);
    bus.GameStartdb = 1'b1;
    cyc();
    chk("off_start_ignored", bus.GameState, 0);
    bus.GameOn = 1'b1;
    cyc();
    chk("level_not_edge", bus.GameState, 0);

    // game 2: start edge coincides with a tick
    bus.GameStartdb = 1'b0;
    cyc();
    bus.GameStartdb = 1'b1; bus.HCount = 17'd0; bus.VCount = 17'd768;
    cyc();
    bus.HCount = 17'd5; bus.VCount = 17'd5;
    chk("g2_state", bus.GameState, 1);
    chk("g2_score", bus.Score, 0);
    chk("g2_lives", bus.Lives, 3);
    chk("g2_pad", bus.PaddleY, 336);
    cyc();
    bus.Bar_up = 1'b1;
    ticks(41);
    chk("pad_t41", bus.PaddleY, 8);
    ticks(1);
    chk("pad_t42", bus.PaddleY, 0);
    ticks(17);
    chk("pad_sat", bus.PaddleY, 0);
    chk("g2_serve59", bus.GameState, 1);
    ticks(1);
    chk("g2_play", bus.GameState, 2);
    for (int k = 0; k < 3; k++) begin
      ticks(379);
      chk("miss_pre_x", bus.BallX, 0);
      chk("miss_pre_state", bus.GameState, 2);
      ticks(1);
      chk("miss_lives", bus.Lives, 2 - k);
      if (k < 2) begin
        chk("miss_state", bus.GameState, 1);
        chk("miss_x", bus.BallX, 504);
        chk("miss_y", bus.BallY, 376);
        ticks(60);
        chk("reserve_play", bus.GameState, 2);
      end else begin
        chk("over_state", bus.GameState, 3);
        chk("over_x", bus.BallX, 0);
        chk("over_y", bus.BallY, 384);
      end
    end
    ticks(5);
    chk("frozen_state", bus.GameState, 3);
    chk("frozen_x", bus.BallX, 0);
    chk("frozen_y", bus.BallY, 384);
    chk("frozen_pad", bus.PaddleY, 0);

    // restart from OVER
    bus.GameStartdb = 1'b0;
    cyc();
    bus.GameStartdb = 1'b1;
    cyc();
    chk("restart_state", bus.GameState, 1);
    chk("restart_lives", bus.Lives, 3);
    chk("restart_score", bus.Score, 0);
    chk("restart_x", bus.BallX, 504);
    bus.Bar_up = 1'b0;
    ticks(60);
    chk("g3_play", bus.GameState, 2);
    ticks(5);
    chk("g3_x", bus.BallX, 524);

    // Clear in the middle of play
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_state", bus.GameState, 0);
    chk("clr_x", bus.BallX, 504);
    chk("clr_y", bus.BallY, 376);
    chk("clr_pad", bus.PaddleY, 336);
    chk("clr_lives", bus.Lives, 0);
    chk("clr_score", bus.Score, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
